// File: rtl/snax_hypercorex_predict_packer.sv
// Packs PredWidth-bit class predictions (LSB lane first) into NarrowDataWidth-bit words.
// Define SNAX_HYPERCOREX_PACK_SKID_EN to add a one-word output holding register.
module snax_hypercorex_predict_packer #(
  parameter int NarrowDataWidth = 64,
  parameter int PredWidth       = 32,
  parameter int CountWidth      = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [CountWidth-1:0]      cfg_num_pred_i,
  input  logic                       cfg_start_i,
  output logic                       busy_o,
  output logic                       done_o,
  input  logic [PredWidth-1:0]       pred_data_i,
  input  logic                       pred_valid_i,
  output logic                       pred_ready_o,
  output logic [NarrowDataWidth-1:0] pack_data_o,
  output logic                       pack_valid_o,
  input  logic                       pack_ready_i
);

  localparam int Lanes        = NarrowDataWidth / PredWidth;
  localparam int LaneIdxWidth = (Lanes > 1) ? $clog2(Lanes) : 1;

  typedef enum logic [1:0] {IDLE, PACK, EMIT, DONE} state_t;

  state_t                      state, state_next;
  logic [CountWidth-1:0]       remaining;
  logic [LaneIdxWidth-1:0]     lane;
  logic [NarrowDataWidth-1:0]  pack_reg;
  logic [NarrowDataWidth-1:0]  word_next;
  logic                        pred_xfer, pack_xfer;
  logic                        last_lane, last_pred, word_done;

  assign pred_xfer = pred_valid_i && pred_ready_o;
  assign pack_xfer = pack_valid_o && pack_ready_i;
  assign last_lane = (lane == LaneIdxWidth'(Lanes - 1));
  assign last_pred = (remaining == CountWidth'(1));
  assign word_done = last_lane || last_pred;

  assign busy_o = (state != IDLE);
  assign done_o = (state == DONE);

  // Packing register with the incoming prediction merged into the current lane
  always_comb begin
    word_next = pack_reg;
    for (int i = 0; i < Lanes; i++) begin
      if (lane == LaneIdxWidth'(i)) word_next[i*PredWidth +: PredWidth] = pred_data_i;
    end
  end

`ifdef SNAX_HYPERCOREX_PACK_SKID_EN
  logic [NarrowDataWidth-1:0] hold_reg;
  logic                       hold_vld;
  logic                       full;
  logic                       hold_free;

  assign hold_free    = !hold_vld || pack_xfer;
  assign pred_ready_o = (state == PACK) && !(full && hold_vld);
  assign pack_valid_o = hold_vld;
  assign pack_data_o  = hold_vld ? hold_reg : '0;
`else
  assign pred_ready_o = (state == PACK);
  assign pack_valid_o = (state == EMIT);
  assign pack_data_o  = pack_valid_o ? pack_reg : '0;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (cfg_start_i) state_next = (cfg_num_pred_i == '0) ? DONE : PACK;
`ifdef SNAX_HYPERCOREX_PACK_SKID_EN
      // EMIT here means draining: the last prediction is in, wait for the final word
      PACK: if (pred_xfer && last_pred) state_next = EMIT;
      EMIT: if (pack_xfer && !full) state_next = DONE;
`else
      PACK: if (pred_xfer && word_done) state_next = EMIT;
      EMIT: if (pack_xfer) state_next = (remaining != '0) ? PACK : DONE;
`endif
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

`ifdef SNAX_HYPERCOREX_PACK_SKID_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      remaining <= '0;
      lane      <= '0;
      pack_reg  <= '0;
      hold_reg  <= '0;
      hold_vld  <= 1'b0;
      full      <= 1'b0;
    end else begin
      if (pack_xfer) hold_vld <= 1'b0;
      if (state == IDLE) begin
        if (cfg_start_i && cfg_num_pred_i != '0) begin
          remaining <= cfg_num_pred_i;
          lane      <= '0;
          pack_reg  <= '0;
          full      <= 1'b0;
        end
      end else if (full && hold_free) begin
        hold_reg <= pack_reg;
        hold_vld <= 1'b1;
        full     <= 1'b0;
        pack_reg <= '0;
        lane     <= '0;
      end else if (pred_xfer) begin
        remaining <= remaining - CountWidth'(1);
        if (word_done) begin
          lane <= '0;
          if (hold_free) begin
            hold_reg <= word_next;
            hold_vld <= 1'b1;
            pack_reg <= '0;
          end else begin
            pack_reg <= word_next;
            full     <= 1'b1;
          end
        end else begin
          pack_reg <= word_next;
          lane     <= lane + LaneIdxWidth'(1);
        end
      end
    end
  end
`else
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      remaining <= '0;
      lane      <= '0;
      pack_reg  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cfg_start_i && cfg_num_pred_i != '0) begin
            remaining <= cfg_num_pred_i;
            lane      <= '0;
            pack_reg  <= '0;
          end
        end
        PACK: begin
          if (pred_xfer) begin
            pack_reg  <= word_next;
            remaining <= remaining - CountWidth'(1);
            if (!word_done) lane <= lane + LaneIdxWidth'(1);
          end
        end
        EMIT: begin
          if (pack_xfer && remaining != '0) begin
            pack_reg <= '0;
            lane     <= '0;
          end
        end
        default: ;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_snax_hypercorex_predict_packer.sv
// Scoreboard bench for snax_hypercorex_predict_packer (default build, 2 lanes of 32 bits).
module tb_snax_hypercorex_predict_packer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] cfg_num_pred = '0;
  logic        cfg_start = 1'b0;
  logic        busy, done;
  logic [31:0] pred_data = '0;
  logic        pred_valid = 1'b0;
  logic        pred_ready;
  logic [63:0] pack_data;
  logic        pack_valid;
  logic        pack_ready = 1'b1;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;
  logic [63:0] exp_q[$];

  always #5 clk = ~clk;

  snax_hypercorex_predict_packer #(
    .NarrowDataWidth(64), .PredWidth(32), .CountWidth(16)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .cfg_num_pred_i(cfg_num_pred), .cfg_start_i(cfg_start),
    .busy_o(busy), .done_o(done),
    .pred_data_i(pred_data), .pred_valid_i(pred_valid), .pred_ready_o(pred_ready),
    .pack_data_o(pack_data), .pack_valid_o(pack_valid), .pack_ready_i(pack_ready)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every presented word must match the scoreboard head; pop on transfer
  always @(negedge clk) begin
    if (done) done_cnt++;
    if (pack_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_word: got %h expected none", pack_data);
      end else begin
        if (pack_data !== exp_q[0]) begin
          errors++;
          $display("FAIL word: got %h expected %h", pack_data, exp_q[0]);
        end
        if (pack_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic start_job(input logic [15:0] n);
    cfg_num_pred = n;
    cfg_start = 1'b1;
    @(posedge clk); #1;
    cfg_start = 1'b0;
  endtask

  task automatic push_pred(input logic [31:0] d);
    int n;
    n = 0;
    pred_data = d;
    pred_valid = 1'b1;
    @(negedge clk);
    while (!pred_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!pred_ready) check("pred_accept_timeout", 64'(pred_ready), 64'd1);
    @(posedge clk); #1;
    pred_valid = 1'b0;
  endtask

  task automatic wait_done(input int target);
    int n;
    n = 0;
    while (done_cnt < target && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("done_count", 64'(done_cnt), 64'(target));
    @(negedge clk);
    check("busy_after_done", 64'(busy), 64'd0);
    check("done_single_pulse", 64'(done), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_pred_ready", 64'(pred_ready), 64'd0);
    check("rst_pack_valid", 64'(pack_valid), 64'd0);
    check("rst_pack_data", pack_data, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Two full words
    exp_q.push_back(64'h00000022_00000011);
    exp_q.push_back(64'h00000044_00000033);
    start_job(16'd4);
    push_pred(32'h11); push_pred(32'h22); push_pred(32'h33); push_pred(32'h44);
    wait_done(1);

    // Odd count: final word zero-padded
    exp_q.push_back(64'h0000000B_0000000A);
    exp_q.push_back(64'h00000000_0000000C);
    start_job(16'd3);
    push_pred(32'hA); push_pred(32'hB); push_pred(32'hC);
    wait_done(2);

    // Zero-length job
    start_job(16'd0);
    @(negedge clk);
    check("zero_done", 64'(done), 64'd1);
    check("zero_pred_ready", 64'(pred_ready), 64'd0);
    check("zero_busy", 64'(busy), 64'd1);
    wait_done(3);

    // Output back-pressure for 5 cycles
    pack_ready = 1'b0;
    exp_q.push_back(64'h00000006_00000005);
    start_job(16'd2);
    push_pred(32'h5); push_pred(32'h6);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_valid", 64'(pack_valid), 64'd1);
      check("stall_pred_ready", 64'(pred_ready), 64'd0);
      @(posedge clk); #1;
    end
    check("stall_word_pending", 64'(exp_q.size()), 64'd1);
    pack_ready = 1'b1;
    wait_done(4);

    // Start while busy is ignored
    exp_q.push_back(64'h00000088_00000077);
    start_job(16'd2);
    push_pred(32'h77);
    start_job(16'd8);
    push_pred(32'h88);
    wait_done(5);
    for (int i = 0; i < 3; i++) @(negedge clk);
    check("ignored_start_idle", 64'(busy), 64'd0);
    check("ignored_start_no_word", 64'(exp_q.size()), 64'd0);

    // Mid-job reset aborts without done and leaves no stale data
    start_job(16'd2);
    push_pred(32'h99);
    rst = 1'b1;
    #1;
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_pred_ready", 64'(pred_ready), 64'd0);
    check("midrst_pack_valid", 64'(pack_valid), 64'd0);
    check("midrst_pack_data", pack_data, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("midrst_no_done", 64'(done_cnt), 64'd5);
    exp_q.push_back(64'h000000BB_000000AA);
    start_job(16'd2);
    push_pred(32'hAA); push_pred(32'hBB);
    wait_done(6);

    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/snax_hypercorex_predict_packer.md
Name: snax_hypercorex_predict_packer

Overview:
- Sits directly downstream of the Hypercorex shell's low-dim prediction output (acc2stream_0) and upstream of the narrow writer streamer.
- Packs PredWidth-bit class predictions, LSB lane first, into NarrowDataWidth-bit words.
- Counts predictions against a programmed total, zero-pads the final partial word, then signals completion.
- Removes the zero-extension waste of one prediction per narrow beat.

Parameters:
- NarrowDataWidth, 64, output word width; integer multiple of PredWidth.
- PredWidth, 32, width of one prediction (equals CsrDataWidth).
- CountWidth, 16, width of the prediction-count configuration.
- Derived: Lanes = NarrowDataWidth/PredWidth; LaneIdxWidth = max(1, $clog2(Lanes)).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- cfg_num_pred_i  in  CountWidth  total predictions for the job; sampled on start
- cfg_start_i  in  1  single-cycle start pulse
- busy_o  out  1  job in progress
- done_o  out  1  one-cycle pulse at job completion
- pred_data_i  in  PredWidth  prediction from the accelerator
- pred_valid_i  in  1  prediction valid
- pred_ready_o  out  1  packer accepts a prediction
- pack_data_o  out  NarrowDataWidth  packed word to the streamer
- pack_valid_o  out  1  packed word valid
- pack_ready_i  in  1  streamer accepts the word

Behaviour:
- Reset (asynchronous, active-high, whole block): state IDLE; counters, lane index and buffers cleared. Outputs busy_o=0, done_o=0, pred_ready_o=0, pack_valid_o=0, pack_data_o=0.
- Handshakes: valid/ready, AXI-stream style.
  - Transfer occurs when valid && ready on the same rising edge.
  - Once pack_valid_o is asserted, pack_valid_o and pack_data_o stay stable until the transfer.
  - pred_ready_o does not depend combinationally on pred_valid_i.
- FSM states: IDLE, PACK, EMIT, DONE.
  - IDLE:
    - cfg_start_i with cfg_num_pred_i>0: latch remaining=cfg_num_pred_i, lane=0, clear the packing register, go to PACK.
    - cfg_start_i with cfg_num_pred_i==0: go to DONE.
    - busy_o=0.
  - PACK:
    - pred_ready_o=1.
    - On each transfer: write pred_data_i into lane [lane*PredWidth +: PredWidth], lane++, remaining--.
    - Go to EMIT when lane reaches Lanes, or when remaining reaches 0 (partial word).
  - EMIT:
    - pack_valid_o=1; pack_data_o=packing register; unfilled upper lanes are 0.
    - On output transfer: if remaining>0, clear the register, set lane=0, go to PACK; else go to DONE.
  - DONE: done_o=1 for exactly one cycle, then IDLE.
  - busy_o=1 in PACK, EMIT and DONE.
- Latency: pack_valid_o rises the cycle after the transfer of the last lane (or the job's last prediction).
- Start handling: cfg_start_i while busy_o=1 is ignored; the configuration is not re-sampled.
- Arithmetic: remaining is a CountWidth-bit down-counter and never underflows (PACK exits at 0). Lane index wraps only via the explicit clear.
- Back-pressure: base build has pred_ready_o=0 throughout EMIT. Peak throughput is Lanes predictions per Lanes+1 cycles.
- Mid-job reset: the job is aborted; no done_o pulse; the partial word is discarded.

Optional Feature:
- Macro: SNAX_HYPERCOREX_PACK_SKID_EN.
- Defined: adds a one-word output holding register.
  - A completed word moves to the holding register, and packing of the next word continues in PACK.
  - pred_ready_o drops only when the holding register is occupied and the packing word is also complete.
  - Sustained throughput: one prediction per cycle while pack_ready_i=1.
  - done_o fires one cycle after the final word transfers.
- Undefined: behaviour exactly as in the base description above.

Test Plan:
- num=4, preds 0x11,0x22,0x33,0x44, pack_ready_i=1 -> two words 0x00000022_00000011 then 0x00000044_00000033; done_o one pulse; busy_o then 0.
- num=3, preds 0xA,0xB,0xC -> words 0x0000000B_0000000A then 0x00000000_0000000C; exactly one done_o pulse.
- num=0 start -> done_o pulses the cycle after start; pack_valid_o never asserts; pred_ready_o stays 0.
- num=2, pack_ready_i held low 5 cycles after pack_valid_o -> pack_data_o stable; pred_ready_o=0 (base build); transfer on the 6th cycle; done follows.
- Second cfg_start_i with num=8 during a num=2 job -> ignored; exactly one word output, then done.
- rst_i asserted after 1 of 2 preds accepted -> all outputs 0 immediately; a new num=2 job then yields a clean word with no stale data.
